sd_init_sequencer: RTL and testbench

- Command sequencer between the memory-mapped I/O block and the SD controller.
- On request, runs the SPI-mode SD card bring-up sequence: CMD0, CMD8, the CMD55/ACMD41 loop, then CMD16 (512-byte blocks).
- Once the card is up, grants software single-command access through a valid/ready port.
- Builds the 48-bit command frames, pulses the controller's start strobe, consumes R1 response bytes, and enforces retry and timeout limits.

---
 rtl/sd_init_sequencer_if.sv | 35 +++
 rtl/sd_init_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// sd_init_sequencer_if : request/response bundle between the I/O block,
//                        the init sequencer and the SD controller
// Revision 1.0
// ============================================================================
interface sd_init_sequencer_if;
  logic        init_start;
  logic        busy;
  logic        ready;
  logic [2:0]  err_code;
  logic        usr_valid;
  logic        usr_ready;
  logic [5:0]  usr_idx;
  logic [31:0] usr_arg;
  logic        usr_respValid;
  logic [7:0]  usr_resp;
  logic [47:0] sd_cmd;
  logic        sd_start;
  logic        sd_respValid;
  logic [7:0]  sd_resp;

  // master: the environment (software side and SD controller)
  modport master (
    output init_start, usr_valid, usr_idx, usr_arg, sd_respValid, sd_resp,
    input  busy, ready, err_code, usr_ready, usr_respValid, usr_resp, sd_cmd, sd_start
  );

  // slave: the sequencer itself
  modport slave (
    input  init_start, usr_valid, usr_idx, usr_arg, sd_respValid, sd_resp,
    output busy, ready, err_code, usr_ready, usr_respValid, usr_resp, sd_cmd, sd_start
  );
endinterface
`default_nettype wire

// File: rtl/sd_init_sequencer.sv
`default_nettype none
// ============================================================================
// sd_init_sequencer : SPI-mode SD card bring-up sequencer with a
//                     single-command user port once the card is ready
// Revision 1.0
// ============================================================================
module sd_init_sequencer #(
  parameter int RETRY_MAX  = 1000,
  parameter int CMD0_TRIES = 8,
  parameter int TIMEOUT    = 4096
) (
  input wire                 clock,
  input wire                 reset,
  sd_init_sequencer_if.slave bus
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_S0    = 4'd1;
  localparam logic [3:0] ST_W0    = 4'd2;
  localparam logic [3:0] ST_S8    = 4'd3;
  localparam logic [3:0] ST_W8    = 4'd4;
  localparam logic [3:0] ST_S55   = 4'd5;
  localparam logic [3:0] ST_W55   = 4'd6;
  localparam logic [3:0] ST_S41   = 4'd7;
  localparam logic [3:0] ST_W41   = 4'd8;
  localparam logic [3:0] ST_S16   = 4'd9;
  localparam logic [3:0] ST_W16   = 4'd10;
  localparam logic [3:0] ST_READY = 4'd11;
  localparam logic [3:0] ST_SU    = 4'd12;
  localparam logic [3:0] ST_WU    = 4'd13;
  localparam logic [3:0] ST_ERROR = 4'd14;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CMD0  = 3'd1;
  localparam logic [2:0] ERR_CMD8  = 3'd2;
  localparam logic [2:0] ERR_CMD55 = 3'd3;
  localparam logic [2:0] ERR_ACMD  = 3'd4;
  localparam logic [2:0] ERR_CMD16 = 3'd5;
  localparam logic [2:0] ERR_TMO   = 3'd6;

  localparam int              C0_W      = $clog2(CMD0_TRIES + 1);
  localparam logic [C0_W-1:0] C0_LIM    = C0_W'(CMD0_TRIES);
  localparam logic [15:0]     RETRY_LIM = 16'(RETRY_MAX);
  localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);

  logic [3:0]      state_q, state_d;
  logic [2:0]      err_q, err_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [C0_W-1:0] c0_q, c0_d;
  logic [15:0]     a41_q, a41_d;
  logic [47:0]     cmd_q, cmd_d;
  logic            usr_rv_q, usr_rv_d;
  logic [7:0]      usr_resp_q, usr_resp_d;

  logic waiting;
  logic start_init;
  logic busy;
  logic ready;
  logic start;

  function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [6:0] crc;
    crc = 7'h7F;
    if (idx == 6'd0 && arg == 32'd0)
      crc = 7'h4A;
    else if (idx == 6'd8 && arg == 32'h0000_01AA)
      crc = 7'h43;
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

  assign waiting = (state_q == ST_W0)  || (state_q == ST_W8)  || (state_q == ST_W55) ||
                   (state_q == ST_W41) || (state_q == ST_W16) || (state_q == ST_WU);
  assign start_init = bus.init_start &&
                      ((state_q == ST_IDLE) || (state_q == ST_READY) || (state_q == ST_ERROR));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_ERROR: if (bus.init_start) state_d = ST_S0;
      ST_READY: begin
        if (bus.init_start)     state_d = ST_S0;
        else if (bus.usr_valid) state_d = ST_SU;
      end
      ST_S0:  state_d = ST_W0;
      ST_W0: if (bus.sd_respValid) begin
        if (bus.sd_resp == 8'h01) state_d = ST_S8;
        else if (c0_q < C0_LIM)   state_d = ST_S0;
        else begin state_d = ST_ERROR; err_d = ERR_CMD0; end
      end
      ST_S8:  state_d = ST_W8;
      ST_W8: if (bus.sd_respValid) begin
        // 0x05 is a version-1 card rejecting CMD8; it still proceeds
        if (bus.sd_resp == 8'h01 || bus.sd_resp == 8'h05) state_d = ST_S55;
        else begin state_d = ST_ERROR; err_d = ERR_CMD8; end
      end
      ST_S55: state_d = ST_W55;
      ST_W55: if (bus.sd_respValid) begin
        if (bus.sd_resp == 8'h00 || bus.sd_resp == 8'h01) state_d = ST_S41;
        else begin state_d = ST_ERROR; err_d = ERR_CMD55; end
      end
      ST_S41: state_d = ST_W41;
      ST_W41: if (bus.sd_respValid) begin
        if (bus.sd_resp == 8'h00)                            state_d = ST_S16;
        else if (bus.sd_resp == 8'h01 && a41_q < RETRY_LIM) state_d = ST_S55;
        else begin state_d = ST_ERROR; err_d = ERR_ACMD; end
      end
      ST_S16: state_d = ST_W16;
      ST_W16: if (bus.sd_respValid) begin
        if (bus.sd_resp == 8'h00) state_d = ST_READY;
        else begin state_d = ST_ERROR; err_d = ERR_CMD16; end
      end
      ST_SU:  state_d = ST_WU;
      ST_WU:  if (bus.sd_respValid) state_d = ST_READY;
      default: state_d = ST_IDLE;
    endcase
    // a response arriving on the expiry cycle takes priority over the timeout
    if (waiting && !bus.sd_respValid && tmo_q == TMO_LAST) begin
      state_d = ST_ERROR;
      err_d   = ERR_TMO;
    end
    if (start_init) err_d = ERR_NONE;
  end

  always_comb begin
    busy  = (state_q >= ST_S0) && (state_q <= ST_W16);
    ready = (state_q == ST_READY);
    start = (state_q == ST_S0)  || (state_q == ST_S8)  || (state_q == ST_S55) ||
            (state_q == ST_S41) || (state_q == ST_S16) || (state_q == ST_SU);
  end

  always_comb begin
    tmo_d = waiting ? tmo_q + 16'd1 : 16'd0;
    c0_d  = c0_q;
    a41_d = a41_q;
    if (start_init) begin
      c0_d  = '0;
      a41_d = '0;
    end else begin
      if (state_q == ST_S0)  c0_d  = c0_q + C0_W'(1);
      if (state_q == ST_S41) a41_d = a41_q + 16'd1;
    end
    cmd_d = cmd_q;
    case (state_d)
      ST_S0:   cmd_d = build_frame(6'd0,  32'd0);
      ST_S8:   cmd_d = build_frame(6'd8,  32'h0000_01AA);
      ST_S55:  cmd_d = build_frame(6'd55, 32'd0);
      ST_S41:  cmd_d = build_frame(6'd41, 32'h4000_0000);
      ST_S16:  cmd_d = build_frame(6'd16, 32'd512);
      ST_SU:   cmd_d = build_frame(bus.usr_idx, bus.usr_arg);
      default: cmd_d = cmd_q;
    endcase
    usr_rv_d   = (state_q == ST_WU) && bus.sd_respValid;
    usr_resp_d = usr_rv_d ? bus.sd_resp : usr_resp_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q      <= ERR_NONE;
      tmo_q      <= '0;
      c0_q       <= '0;
      a41_q      <= '0;
      cmd_q      <= '0;
      usr_rv_q   <= 1'b0;
      usr_resp_q <= '0;
    end else begin
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      c0_q       <= c0_d;
      a41_q      <= a41_d;
      cmd_q      <= cmd_d;
      usr_rv_q   <= usr_rv_d;
      usr_resp_q <= usr_resp_d;
    end
  end

  assign bus.busy          = busy;
  assign bus.ready         = ready;
  assign bus.usr_ready     = ready;
  assign bus.err_code      = err_q;
  assign bus.sd_start      = start;
  assign bus.sd_cmd        = cmd_q;
  assign bus.usr_respValid = usr_rv_q;
  assign bus.usr_resp      = usr_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_init_sequencer.sv
`default_nettype none
// tb_sd_init_sequencer: scripted SD card model, behavioural init model and
// frame/response scoreboard around sd_init_sequencer.
module tb_sd_init_sequencer;
  localparam int RETRY_MAX  = 3;
  localparam int CMD0_TRIES = 8;
  localparam int TIMEOUT    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sd_init_sequencer_if bus();

  sd_init_sequencer #(
    .RETRY_MAX (RETRY_MAX),
    .CMD0_TRIES(CMD0_TRIES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_resp_cyc  = -100;
  int last_issue_cyc = 0;
  int last_start_cyc = 0;
  int stray_cnt  = 0;
  int stray_done = 0;

  logic [47:0] exp_frames[$];
  logic [47:0] seen_frames[$];
  logic [7:0]  exp_uresp[$];
  logic [7:0]  card_bytes[$];
  int          card_delays[$];
  logic [7:0]  script[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [6:0] crc;
    crc = 7'h7F;
    if (idx == 6'd0 && arg == 32'd0) crc = 7'h4A;
    if (idx == 6'd8 && arg == 32'h0000_01AA) crc = 7'h43;
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

  function automatic logic [63:0] outvec();
    return {bus.busy, bus.ready, bus.err_code, bus.usr_ready, bus.usr_respValid,
            bus.usr_resp, bus.sd_cmd, bus.sd_start};
  endfunction

  function automatic logic [7:0] rnd_resp();
    int v;
    v = $urandom_range(0, 9);
    if (v <= 3) return 8'h01;
    if (v <= 6) return 8'h00;
    if (v == 7) return 8'h05;
    if (v == 8) return 8'h7F;
    return 8'($urandom_range(0, 255));
  endfunction

  // Reference: walks the bring-up rules over the scripted card answers,
  // queuing every frame that should appear and the final error code.
  task automatic model_init(output int err, output int used);
    int i;
    logic [7:0] b;
    i = 0; err = 0; used = 0;
    for (int t = 1; t <= CMD0_TRIES; t++) begin
      exp_frames.push_back(frame(6'd0, 32'd0));
      b = script[i]; i++;
      if (b == 8'h01) break;
      if (t == CMD0_TRIES) begin err = 1; used = i; return; end
    end
    exp_frames.push_back(frame(6'd8, 32'h0000_01AA));
    b = script[i]; i++;
    if (b != 8'h01 && b != 8'h05) begin err = 2; used = i; return; end
    for (int a = 1; a <= RETRY_MAX; a++) begin
      exp_frames.push_back(frame(6'd55, 32'd0));
      b = script[i]; i++;
      if (b > 8'h01) begin err = 3; used = i; return; end
      exp_frames.push_back(frame(6'd41, 32'h4000_0000));
      b = script[i]; i++;
      if (b == 8'h00) break;
      if (b != 8'h01 || a == RETRY_MAX) begin err = 4; used = i; return; end
    end
    exp_frames.push_back(frame(6'd16, 32'd512));
    b = script[i]; i++;
    if (b != 8'h00) err = 5;
    used = i;
  endtask

  // Card model: answers each start strobe with the next scripted byte
  initial begin
    logic [7:0] b;
    int d;
    bus.sd_respValid = 1'b0;
    bus.sd_resp      = 8'h00;
    forever begin
      @(negedge clock);
      if (stray_cnt != stray_done) begin
        stray_done++;
        bus.sd_resp = 8'h01;
        bus.sd_respValid = 1'b1;
        @(negedge clock);
        bus.sd_respValid = 1'b0;
      end
      while (!reset && bus.sd_start === 1'b1 && card_bytes.size() > 0) begin
        b = card_bytes.pop_front();
        d = card_delays.pop_front();
        repeat (d + 1) @(negedge clock);
        bus.sd_resp = b;
        bus.sd_respValid = 1'b1;
        last_resp_cyc = cyc;
        @(negedge clock);
        bus.sd_respValid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT emits a frame or a user response
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.sd_start === 1'b1) begin
        last_start_cyc = cyc;
        seen_frames.push_back(bus.sd_cmd);
        if (exp_frames.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_frame: got 0x%0h, expected no frame", bus.sd_cmd);
        end else begin
          check("frame", bus.sd_cmd, exp_frames.pop_front());
        end
        if (last_resp_cyc >= last_issue_cyc) check("start_latency", cyc, last_resp_cyc + 1);
      end
      if (!reset && bus.usr_respValid === 1'b1) begin
        if (exp_uresp.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL unexpected_usr_resp: got 0x%0h, expected no response", bus.usr_resp);
        end else begin
          check("usr_resp", bus.usr_resp, exp_uresp.pop_front());
        end
        check("usr_resp_ready", {bus.ready, bus.usr_ready}, 2'b11);
        check("usr_resp_latency", cyc, last_resp_cyc + 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (bus.busy === 1'b1 && n < 600);
    check({tag, "_busy_drop"}, bus.busy, 1'b0);
  endtask

  task automatic run_init(input string tag, input int first_delay, input bit with_usr, output int err);
    int used;
    model_init(err, used);
    for (int k = 0; k < used; k++) begin
      card_bytes.push_back(script[k]);
      card_delays.push_back((k == 0 && first_delay >= 0) ? first_delay : int'($urandom_range(0, 5)));
    end
    last_issue_cyc = cyc;
    bus.init_start = 1'b1;
    bus.usr_valid  = with_usr;
    bus.usr_idx    = 6'd17;
    bus.usr_arg    = 32'h1234;
    tick();
    bus.init_start = 1'b0;
    bus.usr_valid  = 1'b0;
    check({tag, "_start"}, {bus.busy, bus.ready, bus.err_code}, {1'b1, 1'b0, 3'd0});
    wait_not_busy(tag);
    check({tag, "_ready"}, {bus.ready, bus.usr_ready}, (err == 0) ? 2'b11 : 2'b00);
    check({tag, "_err"}, bus.err_code, err);
    check({tag, "_end_latency"}, cyc, last_resp_cyc + 1);
    check({tag, "_drained"}, exp_frames.size(), 0);
  endtask

  task automatic run_user(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] r, input int d);
    int n;
    exp_frames.push_back(frame(idx, arg));
    exp_uresp.push_back(r);
    card_bytes.push_back(r);
    card_delays.push_back(d);
    last_issue_cyc = cyc;
    bus.usr_valid = 1'b1;
    bus.usr_idx   = idx;
    bus.usr_arg   = arg;
    tick();
    bus.usr_valid = 1'b0;
    check({tag, "_accept"}, {bus.ready, bus.usr_ready, bus.busy, bus.sd_start}, 4'b0001);
    n = 0;
    do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 100);
    check({tag, "_ready_back"}, bus.ready, 1'b1);
    check({tag, "_drained"}, exp_frames.size() + exp_uresp.size(), 0);
  endtask

  task automatic good_script();
    int n;
    script.delete();
    n = $urandom_range(0, 2);
    repeat (n) script.push_back(8'($urandom_range(2, 255)));
    script.push_back(8'h01);
    script.push_back($urandom_range(0, 1) ? 8'h01 : 8'h05);
    n = $urandom_range(0, RETRY_MAX - 1);
    repeat (n) begin script.push_back(8'h01); script.push_back(8'h01); end
    script.push_back($urandom_range(0, 1) ? 8'h00 : 8'h01);
    script.push_back(8'h00);
    script.push_back(8'h00);
  endtask

  initial begin
    int err;
    int base;
    int n41;
    int s;
    bus.init_start = 1'b0;
    bus.usr_valid  = 1'b0;
    bus.usr_idx    = '0;
    bus.usr_arg    = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_outputs", outvec(), 64'd0);

    base = seen_frames.size();
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    run_init("basic", -1, 1'b0, err);
    check("basic_frame_count", seen_frames.size() - base, 7);
    if (seen_frames.size() >= base + 2) begin
      check("cmd0_frame", seen_frames[base], 48'h40_0000_0000_95);
      check("cmd8_frame", seen_frames[base + 1], 48'h48_0000_01AA_87);
    end

    run_user("usr17", 6'd17, 32'h0000_0200, 8'h00, 2);
    check("usr17_cmd", bus.sd_cmd, 48'h51_0000_0200_FF);
    run_user("usr_a5", 6'd24, 32'hDEAD_BEEF, 8'hA5, 0);
    repeat (3) tick();
    check("usr_resp_held", {bus.usr_respValid, bus.usr_resp}, {1'b0, 8'hA5});

    good_script();
    run_init("init_wins", -1, 1'b1, err);

    script = '{8'h01, 8'h05, 8'h01, 8'h00, 8'h00};
    run_init("cmd8_v1", -1, 1'b0, err);
    script = '{8'h01, 8'h7F};
    run_init("cmd8_bad", -1, 1'b0, err);

    base = seen_frames.size();
    script = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_init("acmd_busy", -1, 1'b0, err);
    n41 = 0;
    for (int k = base; k < seen_frames.size(); k++)
      if (seen_frames[k][45:40] == 6'd41) n41++;
    check("acmd_busy_count", n41, RETRY_MAX);

    good_script();
    run_init("reinit", -1, 1'b0, err);

    base = seen_frames.size();
    script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_init("cmd0_fail", -1, 1'b0, err);
    check("cmd0_fail_count", seen_frames.size() - base, CMD0_TRIES);

    script = '{8'h01, 8'h01, 8'h04};
    run_init("cmd55_bad", -1, 1'b0, err);
    script = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h05};
    run_init("cmd16_bad", -1, 1'b0, err);

    // silent card: error must land exactly TIMEOUT cycles after W0 entry
    exp_frames.push_back(frame(6'd0, 32'd0));
    last_issue_cyc = cyc;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    s = last_start_cyc;
    while (cyc < s + TIMEOUT) tick();
    check("tmo_before", {bus.busy, bus.err_code}, {1'b1, 3'd0});
    tick();
    check("tmo_after", {bus.busy, bus.ready, bus.err_code}, {1'b0, 1'b0, 3'd6});
    check("tmo_drained", exp_frames.size(), 0);

    script = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    run_init("tmo_edge", TIMEOUT - 1, 1'b0, err);

    for (int it = 0; it < 16; it++) begin
      if (it % 2 == 0) good_script();
      else begin
        script.delete();
        repeat (20) script.push_back(rnd_resp());
      end
      run_init("rand", -1, 1'b0, err);
      if (err == 0) begin
        repeat (2) run_user("rand_usr", 6'($urandom_range(0, 63)), $urandom(),
                            8'($urandom_range(0, 255)), $urandom_range(0, 5));
      end
    end

    // reset while waiting for ACMD41's answer
    script.delete();
    exp_frames.push_back(frame(6'd0, 32'd0));
    exp_frames.push_back(frame(6'd8, 32'h0000_01AA));
    exp_frames.push_back(frame(6'd55, 32'd0));
    exp_frames.push_back(frame(6'd41, 32'h4000_0000));
    repeat (3) begin card_bytes.push_back(8'h01); card_delays.push_back(1); end
    last_issue_cyc = cyc;
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    s = 0;
    while (exp_frames.size() != 0 && s < 200) begin tick(); s++; end
    check("w41_reached", exp_frames.size(), 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset_w41_outputs", outvec(), 64'd0);
    reset = 1'b0;
    base = seen_frames.size();
    stray_cnt++;
    repeat (10) tick();
    check("stray_outputs", outvec(), 64'd0);
    check("stray_no_frame", seen_frames.size() - base, 0);
    good_script();
    run_init("after_reset", -1, 1'b0, err);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
